// File: rtl/fetch_req_ctrl_pkg.sv
// rtl/fetch_req_ctrl_pkg.sv - shared fetch-stage types, defaults and helpers
package fetch_req_ctrl_pkg;

    localparam int          DEFAULT_FETCH_WIDTH = 2;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'hbfc00000;
    localparam logic [4:0]  EXCCODE_ADEL        = 5'h04;

    typedef struct packed {
        logic [31:0]                          pc;
        logic [DEFAULT_FETCH_WIDTH-1:0][31:0] inst;
        logic [DEFAULT_FETCH_WIDTH-1:0]       mask;
        logic                                 ex;
    } fetch_entry_t;

    function automatic logic [31:0] group_base(input logic [31:0] pc, input int fetch_width);
        return pc & ~(32'(fetch_width * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != FULL) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - fetch PC owner issuing pipelined icache requests into a response buffer
module fetch_req_ctrl
    import fetch_req_ctrl_pkg::*;
#(
    parameter int          FETCH_WIDTH     = DEFAULT_FETCH_WIDTH,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      pred_valid,
    input  logic                      pred_taken,
    input  logic [31:0]               pred_target,
    output logic                      icache_req,
    output logic [31:0]               icache_vaddr,
    input  logic                      icache_addr_ok,
    input  logic                      icache_data_ok,
    input  logic [32*FETCH_WIDTH-1:0] icache_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_inst,
    output logic [FETCH_WIDTH-1:0]    out_mask,
    output logic                      out_ex
);
    localparam int          GB     = FETCH_WIDTH * 4;
    localparam int          IW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int          BW     = $clog2(BUF_DEPTH + 1);
    localparam int          TAG_W  = 32 + FETCH_WIDTH;
    localparam int          ENT_W  = 32 + 32 * FETCH_WIDTH + FETCH_WIDTH + 1;
    localparam logic [31:0] MAX_OS = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] BUF_D  = 32'(BUF_DEPTH);

    logic [31:0]               pc;
    logic                      pc_valid;
    logic                      ex_pending;
    logic [IW-1:0]             inflight;
    logic [IW-1:0]             cancel_cnt;
    logic [BW-1:0]             buf_count;
    logic [31:0]               first_slot;
    logic [FETCH_WIDTH-1:0]    cur_mask;
    logic [TAG_W-1:0]          tag_head;
    logic [31:0]               tag_pc;
    logic [FETCH_WIDTH-1:0]    tag_mask;
    logic [ENT_W-1:0]          out_push_data;
    logic [ENT_W-1:0]          out_head;
    logic [31:0]               head_pc;
    logic [32*FETCH_WIDTH-1:0] head_inst;
    logic [FETCH_WIDTH-1:0]    head_mask;
    logic                      head_ex;
    logic                      misaligned;
    logic                      credit_ok;
    logic                      issue;
    logic                      drop;
    logic                      data_push;
    logic                      ex_push;
    logic                      out_push;
    logic                      out_pop;

    assign icache_vaddr = group_base(pc, FETCH_WIDTH);
    assign misaligned   = pc[1:0] != 2'b00;

    always_comb begin
        cur_mask   = '0;
        first_slot = (pc >> 2) & 32'(FETCH_WIDTH - 1);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            cur_mask[i] = 32'(i) >= first_slot;
        end
    end

    // Counting buffered entries against credits means every response has a slot waiting.
    assign credit_ok  = (32'(inflight) < MAX_OS) && ((32'(inflight) + 32'(buf_count)) < BUF_D);
    assign icache_req = pc_valid && !redirect_valid && !misaligned && !ex_pending && credit_ok;
    assign issue      = icache_req && icache_addr_ok;

    assign drop      = redirect_valid || (cancel_cnt != '0);
    assign data_push = icache_data_ok && !drop;
    assign ex_push   = pc_valid && misaligned && !ex_pending && !redirect_valid &&
                       (inflight == '0) && (cancel_cnt == '0) && (32'(buf_count) < BUF_D);
    assign out_push  = data_push || ex_push;

    assign {tag_pc, tag_mask} = tag_head;
    assign out_push_data = ex_push ? {pc, {(32*FETCH_WIDTH){1'b0}}, {FETCH_WIDTH{1'b0}}, 1'b1}
                                   : {tag_pc, icache_rdata, tag_mask, 1'b0};

    assign {head_pc, head_inst, head_mask, head_ex} = out_head;
    assign out_valid = buf_count != '0;
    assign out_pop   = out_valid && out_ready;
    assign out_pc    = head_pc;
    assign out_inst  = head_inst;
    assign out_mask  = out_valid ? head_mask : '0;
    assign out_ex    = out_valid && head_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            pc_valid   <= 1'b0;
            ex_pending <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            pc_valid <= 1'b1;
            if (redirect_valid) begin
                pc         <= redirect_pc;
                ex_pending <= 1'b0;
                // inflight already counts earlier cancellations, so recomputing is safe.
                cancel_cnt <= inflight - IW'(icache_data_ok);
            end else begin
                if (issue) begin
                    pc <= (pred_valid && pred_taken) ? pred_target : icache_vaddr + 32'(GB);
                end
                if (ex_push) begin
                    ex_pending <= 1'b1;
                end
                if (icache_data_ok && (cancel_cnt != '0)) begin
                    cancel_cnt <= cancel_cnt - IW'(1);
                end
            end
        end
    end

    // Tag FIFO occupancy is exactly the number of accepted, unanswered requests.
    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (issue),
        .push_data ({pc, cur_mask}),
        .pop       (icache_data_ok),
        .pop_data  (tag_head),
        .count     (inflight)
    );

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) out_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (out_push),
        .push_data (out_push_data),
        .pop       (out_pop),
        .pop_data  (out_head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb/tb_fetch_req_ctrl.sv - directed self-checking bench for fetch_req_ctrl
module tb_fetch_req_ctrl;
    localparam int FW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset          = 1'b1;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc    = '0;
    logic             pred_valid     = 1'b0;
    logic             pred_taken     = 1'b0;
    logic [31:0]      pred_target    = '0;
    logic             icache_req;
    logic [31:0]      icache_vaddr;
    logic             icache_addr_ok = 1'b0;
    logic             icache_data_ok = 1'b0;
    logic [32*FW-1:0] icache_rdata   = '0;
    logic             out_valid;
    logic             out_ready      = 1'b0;
    logic [31:0]      out_pc;
    logic [32*FW-1:0] out_inst;
    logic [FW-1:0]    out_mask;
    logic             out_ex;

    fetch_req_ctrl #(
        .FETCH_WIDTH     (FW),
        .MAX_OUTSTANDING (4),
        .BUF_DEPTH       (4),
        .RESET_PC        (32'hbfc00000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .icache_req     (icache_req),
        .icache_vaddr   (icache_vaddr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata   (icache_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_mask       (out_mask),
        .out_ex         (out_ex)
    );

    typedef struct { logic [31:0] vaddr; int t; } pend_t;
    typedef struct { logic [31:0] pc; logic [FW-1:0] mask; logic ex; logic [32*FW-1:0] inst; } obs_t;
    typedef struct { logic [31:0] rpc; logic ex; logic [31:0] vaddr; logic [31:0] pc; logic [FW-1:0] mask; } vec_t;

    pend_t       pend[$];
    logic [31:0] reqs[$];
    obs_t        outs[$];
    int          cyc      = 0;
    int          lat      = 2;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          data_en  = 1'b0;
    bit          pred_en  = 1'b0;
    logic [31:0] pred_at  = '0;

    function automatic logic [32*FW-1:0] rd_of(input logic [31:0] v);
        return {~(v + 32'd4), ~v};
    endfunction

    function automatic logic [31:0] req_at(input int k);
        return (k < reqs.size()) ? reqs[k] : 32'hdeadbeef;
    endfunction

    function automatic obs_t out_at(input int k);
        obs_t o;
        o = '{32'hdeadbeef, 'x, 1'bx, 'x};
        if (k < outs.size()) o = outs[k];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Observe handshakes just after the inputs settle, then advance one cycle and drive the icache model.
    task automatic tick();
        #1;
        if (icache_req && icache_addr_ok) begin
            reqs.push_back(icache_vaddr);
            pend.push_back('{icache_vaddr, cyc});
        end
        if (icache_data_ok) void'(pend.pop_front());
        if (out_valid && out_ready) outs.push_back('{out_pc, out_mask, out_ex, out_inst});
        @(posedge clk);
        @(negedge clk);
        cyc++;
        icache_data_ok = data_en && (pend.size() > 0) && ((cyc - pend[0].t) >= lat);
        icache_rdata   = (pend.size() > 0) ? rd_of(pend[0].vaddr) : '0;
        pred_valid     = pred_en && (icache_vaddr == pred_at);
        pred_taken     = pred_valid;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        icache_addr_ok = 1'b0;
        data_en        = 1'b1;
        out_ready      = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (pend.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
        reqs.delete();
        outs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required below 100000", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        obs_t o;
        vecs[0] = '{32'h80000000, 1'b0, 32'h80000000, 32'h80000000, 2'b11};
        vecs[1] = '{32'h80000004, 1'b0, 32'h80000000, 32'h80000004, 2'b10};
        vecs[2] = '{32'h1234567c, 1'b0, 32'h12345678, 32'h1234567c, 2'b10};
        vecs[3] = '{32'h00000010, 1'b0, 32'h00000010, 32'h00000010, 2'b11};
        vecs[4] = '{32'h80000002, 1'b1, 32'h0,        32'h80000002, 2'b00};
        vecs[5] = '{32'hbfc00007, 1'b1, 32'h0,        32'hbfc00007, 2'b00};

        repeat (3) tick();
        check("reset_icache_req", 64'(icache_req), 64'd0);
        check("reset_out_valid",  64'(out_valid),  64'd0);
        check("reset_out_ex",     64'(out_ex),     64'd0);
        check("reset_out_mask",   64'(out_mask),   64'd0);

        // Sequential stream from the reset PC.
        reqs.delete();
        outs.delete();
        reset = 1'b0; icache_addr_ok = 1'b1; data_en = 1'b1; out_ready = 1'b1;
        repeat (14) tick();
        for (int k = 0; k < 6; k++)
            check($sformatf("stream_vaddr%0d", k), 64'(req_at(k)), 64'(32'hbfc00000 + 32'(8 * k)));
        for (int k = 0; k < 4; k++) begin
            o = out_at(k);
            check($sformatf("stream_pc%0d", k),   64'(o.pc),   64'(32'hbfc00000 + 32'(8 * k)));
            check($sformatf("stream_mask%0d", k), 64'(o.mask), 64'(2'b11));
            check($sformatf("stream_ex%0d", k),   64'(o.ex),   64'd0);
            check($sformatf("stream_inst%0d", k), 64'(o.inst), 64'(rd_of(32'hbfc00000 + 32'(8 * k))));
        end
        drain();

        // Responses stalled: issue stops at four outstanding.
        icache_addr_ok = 1'b1; data_en = 1'b0; out_ready = 1'b1;
        redirect_to(32'h00001000);
        repeat (8) tick();
        check("os_nreq",       64'(reqs.size()), 64'd4);
        check("os_icache_req", 64'(icache_req),  64'd0);
        drain();
        check("os_nout", 64'(outs.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("os_pc%0d", k), 64'(out_at(k).pc), 64'(32'h00001000 + 32'(8 * k)));

        // Consumer stalled: buffer plus in-flight never exceeds four, nothing lost.
        icache_addr_ok = 1'b1; data_en = 1'b1; out_ready = 1'b0;
        redirect_to(32'h00002000);
        repeat (12) tick();
        check("bp_nreq",       64'(reqs.size()), 64'd4);
        check("bp_icache_req", 64'(icache_req),  64'd0);
        check("bp_out_valid",  64'(out_valid),   64'd1);
        check("bp_nout_held",  64'(outs.size()), 64'd0);
        drain();
        check("bp_nout", 64'(outs.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            o = out_at(k);
            check($sformatf("bp_pc%0d", k),   64'(o.pc),   64'(32'h00002000 + 32'(8 * k)));
            check($sformatf("bp_inst%0d", k), 64'(o.inst), 64'(rd_of(32'h00002000 + 32'(8 * k))));
        end

        // Three in flight, redirect lands with a response in the same cycle.
        icache_addr_ok = 1'b1; data_en = 1'b0; out_ready = 1'b1;
        redirect_to(32'h00003000);
        repeat (3) tick();
        check("cancel_nreq_old", 64'(reqs.size()), 64'd3);
        icache_addr_ok = 1'b0; data_en = 1'b1;
        tick();
        redirect_to(32'h80000004);
        icache_addr_ok = 1'b1;
        repeat (16) tick();
        check("cancel_vaddr0", 64'(req_at(0)), 64'(32'h80000000));
        o = out_at(0);
        check("cancel_pc0",   64'(o.pc),   64'(32'h80000004));
        check("cancel_mask0", 64'(o.mask), 64'(2'b10));
        check("cancel_inst0", 64'(o.inst), 64'(rd_of(32'h80000000)));
        o = out_at(1);
        check("cancel_pc1",   64'(o.pc),   64'(32'h80000008));
        check("cancel_mask1", 64'(o.mask), 64'(2'b11));

        // Predicted-taken branch in group 0xbfc00008.
        pred_en = 1'b1; pred_at = 32'hbfc00008; pred_target = 32'hbfc00104;
        redirect_to(32'hbfc00000);
        repeat (12) tick();
        pred_en = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0;
        check("pred_vaddr0", 64'(req_at(0)), 64'(32'hbfc00000));
        check("pred_vaddr1", 64'(req_at(1)), 64'(32'hbfc00008));
        check("pred_vaddr2", 64'(req_at(2)), 64'(32'hbfc00100));
        check("pred_vaddr3", 64'(req_at(3)), 64'(32'hbfc00108));
        o = out_at(2);
        check("pred_pc2",   64'(o.pc),   64'(32'hbfc00104));
        check("pred_mask2", 64'(o.mask), 64'(2'b10));

        // Redirect table, including misaligned targets that raise AdEL and stall.
        for (int v = 0; v < 6; v++) begin
            icache_addr_ok = 1'b1; data_en = 1'b1; out_ready = 1'b1;
            redirect_to(vecs[v].rpc);
            repeat (12) tick();
            if (vecs[v].ex) begin
                check($sformatf("vec%0d_nreq", v),       64'(reqs.size()), 64'd0);
                check($sformatf("vec%0d_nout", v),       64'(outs.size()), 64'd1);
                check($sformatf("vec%0d_icache_req", v), 64'(icache_req),  64'd0);
            end else begin
                check($sformatf("vec%0d_vaddr", v), 64'(req_at(0)), 64'(vecs[v].vaddr));
            end
            o = out_at(0);
            check($sformatf("vec%0d_pc", v),   64'(o.pc),   64'(vecs[v].pc));
            check($sformatf("vec%0d_mask", v), 64'(o.mask), 64'(vecs[v].mask));
            check($sformatf("vec%0d_ex", v),   64'(o.ex),   64'(vecs[v].ex));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
